// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO between IF and ID, with IF freeze backpressure
// and branch flush. Optional zero-latency bypass via FETCH_QUEUE_BYPASS_EN.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   ifPC, ifInstruction       word fetched by IF this cycle
//   brTaken                   taken branch; flushes all queued entries
//   freeze                    backpressure to IF (queue full)
//   idValid, idReady          head handshake toward ID
//   idPC, idInstruction       head entry (zero when nothing is valid)
//   count                     occupancy, 0..DEPTH
module fetch_queue #(
  parameter int WORD_SIZE  = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  ifPC,
  input  logic [WORD_SIZE-1:0]  ifInstruction,
  input  logic                  brTaken,
  output logic                  freeze,
  output logic                  idValid,
  input  logic                  idReady,
  output logic [WORD_SIZE-1:0]  idPC,
  output logic [WORD_SIZE-1:0]  idInstruction,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] CNT_ONE = 1;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  typedef logic [2*WORD_SIZE-1:0] entry_t;

  entry_t mem_q [DEPTH];

  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;

  logic   empty;
  logic   push;
  logic   pop;
  logic   byp;
  logic   wr_en;
  logic   rd_adv;
  entry_t head;

  assign empty  = (count_q == '0);
  assign freeze = (count_q == FULL);
  assign push   = ~freeze & ~brTaken & rst;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = empty & push;
`else
  assign byp = 1'b0;
`endif

  assign idValid = ~empty | byp;
  assign pop     = idValid & idReady;

  // A bypassed word taken by ID this cycle never enters storage.
  assign wr_en  = push & ~(byp & idReady);
  assign rd_adv = pop & ~empty;

  always_comb begin
    head = '0;
    if (byp) begin
      head = {ifPC, ifInstruction};
    end else if (!empty) begin
      head = mem_q[rd_ptr_q];
    end
  end

  assign idPC          = head[2*WORD_SIZE-1:WORD_SIZE];
  assign idInstruction = head[WORD_SIZE-1:0];
  assign count         = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (brTaken) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_adv) rd_ptr_d = rd_ptr_q + PTR_ONE;
      unique case ({wr_en, rd_adv})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {ifPC, ifInstruction};
  end

endmodule
